// File: rtl/sb_ram_pkg.sv
// Shared constants and types for the tiled SB_RAM40_4K memory (sb_ram_array).
package sb_ram_pkg;

  localparam int PHYS_DEPTH  = 1024;
  localparam int PHYS_WIDTH  = 4;
  localparam int PHYS_AWIDTH = 11;

  localparam int READ_MODE_1024X4  = 2;
  localparam int WRITE_MODE_1024X4 = 2;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

endpackage

// File: rtl/sb_ram_tile.sv
// One SB_RAM40_4K column in 1024x4 mode: nibble write/read ports, registered read,
// 11-bit primitive address with the MSB tied low.
module sb_ram_tile
  import sb_ram_pkg::*;
#(
  parameter int           READ_MODE  = READ_MODE_1024X4,
  parameter int           WRITE_MODE = WRITE_MODE_1024X4,
  parameter logic [255:0] INIT_0 = '0,
  parameter logic [255:0] INIT_1 = '0,
  parameter logic [255:0] INIT_2 = '0,
  parameter logic [255:0] INIT_3 = '0,
  parameter logic [255:0] INIT_4 = '0,
  parameter logic [255:0] INIT_5 = '0,
  parameter logic [255:0] INIT_6 = '0,
  parameter logic [255:0] INIT_7 = '0,
  parameter logic [255:0] INIT_8 = '0,
  parameter logic [255:0] INIT_9 = '0,
  parameter logic [255:0] INIT_A = '0,
  parameter logic [255:0] INIT_B = '0,
  parameter logic [255:0] INIT_C = '0,
  parameter logic [255:0] INIT_D = '0,
  parameter logic [255:0] INIT_E = '0,
  parameter logic [255:0] INIT_F = '0
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [9:0]            waddr,
  input  logic [PHYS_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [9:0]            raddr,
  output logic [PHYS_WIDTH-1:0] rdata
);

  localparam logic [255:0] INIT_ALL = INIT_0 | INIT_1 | INIT_2 | INIT_3 | INIT_4 | INIT_5 |
                                      INIT_6 | INIT_7 | INIT_8 | INIT_9 | INIT_A | INIT_B |
                                      INIT_C | INIT_D | INIT_E | INIT_F;

  // The behavioural model implements 1024x4 mode only and starts with undefined contents;
  // non-default modes and INIT data take effect on the hard primitive alone.
  if (READ_MODE != READ_MODE_1024X4 || WRITE_MODE != WRITE_MODE_1024X4 || INIT_ALL != '0)
  begin : g_prim_cfg_unmodelled
  end

  logic [PHYS_AWIDTH-1:0] waddr_full;
  logic [PHYS_AWIDTH-1:0] raddr_full;
  logic [PHYS_WIDTH-1:0]  mem [0:(2**PHYS_AWIDTH)-1];
  logic [PHYS_WIDTH-1:0]  rdata_q;

  assign waddr_full = {1'b0, waddr};
  assign raddr_full = {1'b0, raddr};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr_full] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr_full];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sb_ram_array.sv
// Parametrised RAM tiled from 1024x4 columns with byte masking, write-first bypass and
// post-reset clear sweep. Define SB_RAM_ARRAY_OUTREG_EN for an extra output register stage.
module sb_ram_array
  import sb_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter bit ZERO_INIT  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    req_ready,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_done
);

  localparam int     COLS        = DATA_WIDTH / PHYS_WIDTH;
  localparam int     ROWS        = 2 ** (ADDR_WIDTH - 10);
  localparam int     ROW_BITS    = (ADDR_WIDTH > 10) ? ADDR_WIDTH - 10 : 1;
  localparam int     ROW_SLOTS   = 2 ** ROW_BITS;
  localparam state_e RESET_STATE = ZERO_INIT ? INIT : IDLE;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_seen_q, rd_seen_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [DATA_WIDTH-1:0] byp_mask_q, byp_mask_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  logic                  clearing, wr_fire, rd_fire;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata, be_mask, rd_merged;
  logic [COLS-1:0]       mem_we;
  logic [ROW_BITS-1:0]   wr_row, rd_row;
  logic [DATA_WIDTH-1:0] row_rdata [ROW_SLOTS];

  assign req_ready = (state_q == IDLE);
  assign init_done = (state_q == IDLE);
  assign clearing  = (state_q == INIT);
  assign wr_fire   = wr_en & req_ready;
  assign rd_fire   = rd_en & req_ready;
  assign mem_waddr = clearing ? cnt_q : wr_addr;
  assign mem_wdata = clearing ? '0 : wr_data;

  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_be_mask
    assign be_mask[8*gi +: 8] = {8{wr_be[gi]}};
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col_we
    assign mem_we[gi] = clearing | (wr_fire & wr_be[gi/2]);
  end

  if (ADDR_WIDTH > 10) begin : g_row_sel
    assign wr_row = mem_waddr[ADDR_WIDTH-1:10];
    assign rd_row = rd_addr[ADDR_WIDTH-1:10];
  end else begin : g_single_row
    assign wr_row = '0;
    assign rd_row = '0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_fire;
    rd_seen_d  = rd_seen_q | rd_fire;
    row_d      = row_q;
    byp_mask_d = byp_mask_q;
    byp_data_d = byp_data_q;
    if (state_q == INIT) begin
      // The last address is written in the same cycle as the move to IDLE; no wrap.
      if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
      end
    end
    if (rd_fire) begin
      row_d      = rd_row;
      byp_mask_d = (wr_fire && (wr_addr == rd_addr)) ? be_mask : '0;
      byp_data_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      row_q      <= '0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_seen_q  <= rd_seen_d;
      row_q      <= row_d;
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
    end
  end

  for (genvar gi = 0; gi < ROW_SLOTS; gi++) begin : g_row
    if (gi < ROWS) begin : g_tiles
      logic [DATA_WIDTH-1:0] rdata_row;
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
        sb_ram_tile u_tile (
          .clk   (clk),
          .we    (mem_we[gj] && (wr_row == ROW_BITS'(gi))),
          .waddr (mem_waddr[9:0]),
          .wdata (mem_wdata[PHYS_WIDTH*gj +: PHYS_WIDTH]),
          .re    (rd_fire && (rd_row == ROW_BITS'(gi))),
          .raddr (rd_addr[9:0]),
          .rdata (rdata_row[PHYS_WIDTH*gj +: PHYS_WIDTH])
        );
      end
      assign row_rdata[gi] = rdata_row;
    end else begin : g_empty
      assign row_rdata[gi] = '0;
    end
  end

  // Tile read registers power up undefined, so output stays 0 until the first accepted read.
  assign rd_merged = rd_seen_q ? ((row_rdata[row_q] & ~byp_mask_q) | (byp_data_q & byp_mask_q))
                               : '0;

`ifdef SB_RAM_ARRAY_OUTREG_EN
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  always_comb begin
    out_valid_d = rd_valid_q;
    out_data_d  = rd_valid_q ? rd_merged : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rd_valid = out_valid_q;
  assign rd_data  = out_data_q;
`else
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_merged;
`endif

endmodule

// File: tb/tb_sb_ram_array.sv
// Self-checking bench for sb_ram_array: table-driven vectors on a 1024-deep instance,
// row-select checks on a 4096-deep instance, and reset/sweep corner sequences.
module tb_sb_ram_array;

`ifdef SB_RAM_ARRAY_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic        on_b;
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_ready, a_wr_en, a_rd_en, a_valid, a_done;
  logic [9:0]  a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data, a_rd_data;
  logic [3:0]  a_wr_be;

  logic        b_ready, b_wr_en, b_rd_en, b_valid, b_done;
  logic [11:0] b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data, b_rd_data;
  logic [3:0]  b_wr_be;

  sb_ram_array #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .ZERO_INIT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_ready(a_ready),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_valid),
    .init_done(a_done)
  );

  sb_ram_array #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .ZERO_INIT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_ready(b_ready),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_valid),
    .init_done(b_done)
  );

  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic mon_en = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en && (a_valid || b_valid)) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_rd_valid: a=%0b b=%0b at cycle %0d, required no read outstanding",
                 a_valid, b_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_data"}, mon_e.on_b ? b_rd_data : a_rd_data, mon_e.data);
        check({mon_e.name, "_lat"}, 32'(cyc), 32'(mon_e.due));
        $display("read %s: a_valid=%0b b_valid=%0b data=0x%08h", mon_e.name, a_valid, b_valid,
                 mon_e.on_b ? b_rd_data : a_rd_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input vec_t v);
    a_wr_en = v.wr_en; a_wr_addr = v.wr_addr; a_wr_data = v.wr_data; a_wr_be = v.wr_be;
    a_rd_en = v.rd_en; a_rd_addr = v.rd_addr;
    if (v.rd_en) sb.push_back('{on_b: 1'b0, data: v.exp_data, due: cyc + LAT, name: v.name});
    tick();
    a_wr_en = 1'b0;
    a_rd_en = 1'b0;
  endtask

  task automatic drive_b(input logic we, input logic [11:0] addr, input logic [31:0] data,
                         input string nm);
    b_wr_en = we; b_wr_addr = addr; b_wr_data = data; b_wr_be = 4'hF;
    b_rd_en = ~we; b_rd_addr = addr;
    if (!we) sb.push_back('{on_b: 1'b1, data: data, due: cyc + LAT, name: nm});
    tick();
    b_wr_en = 1'b0;
    b_rd_en = 1'b0;
  endtask

  task automatic add_vec(input logic we, input logic [9:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [9:0] ra,
                         input logic [31:0] ex, input string nm);
    vq.push_back('{wr_en: we, wr_addr: wa, wr_data: wd, wr_be: be, rd_en: re, rd_addr: ra,
                   exp_data: ex, name: nm});
  endtask

  // Counts clock edges from now until dut_a raises req_ready; bounded.
  task automatic sweep_a(output int n);
    n = 0;
    while (!a_ready && n < 5000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [11:0] b_addrs [5];
    logic [31:0] b_vals [5];

    a_wr_en = 0; a_rd_en = 0; a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0; a_wr_be = '0;
    b_wr_en = 0; b_rd_en = 0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0; b_wr_be = '0;

    add_vec(1, 10'h3A5, 32'hDEADBEEF, 4'hF, 0, 10'h000, 32'h0,        "wr_3a5");
    add_vec(0, 10'h000, 32'h0,        4'h0, 1, 10'h3A5, 32'hDEADBEEF, "rd_3a5");
    add_vec(0, 10'h000, 32'h0,        4'h0, 1, 10'h3FF, 32'h00000000, "rd_3ff_cleared");
    add_vec(0, 10'h000, 32'h0,        4'h0, 1, 10'h000, 32'h00000000, "rd_000_dropped_wr");
    add_vec(1, 10'h010, 32'h11223344, 4'hF, 0, 10'h000, 32'h0,        "wr_010_full");
    add_vec(1, 10'h010, 32'hAABBCCDD, 4'h5, 0, 10'h000, 32'h0,        "wr_010_be5");
    add_vec(0, 10'h000, 32'h0,        4'h0, 1, 10'h010, 32'h11BB33DD, "rd_010_masked");
    add_vec(1, 10'h020, 32'h12345678, 4'hF, 0, 10'h000, 32'h0,        "wr_020_full");
    add_vec(1, 10'h020, 32'hCAFEF00D, 4'h3, 1, 10'h020, 32'h1234F00D, "rdwr_020_bypass");
    add_vec(0, 10'h000, 32'h0,        4'h0, 1, 10'h020, 32'h1234F00D, "rd_020_stored");
    add_vec(1, 10'h030, 32'h55555555, 4'h0, 1, 10'h030, 32'h00000000, "rdwr_030_be0");
    add_vec(0, 10'h000, 32'h0,        4'h0, 1, 10'h030, 32'h00000000, "rd_030_noop");
    add_vec(1, 10'h040, 32'hA5A5A5A5, 4'hF, 1, 10'h3A5, 32'hDEADBEEF, "rdwr_indep");
    add_vec(0, 10'h000, 32'h0,        4'h0, 1, 10'h040, 32'hA5A5A5A5, "rd_040");

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", a_ready, 0);
    check("reset_rd_valid", a_valid, 0);
    check("reset_rd_data", a_rd_data, 0);
    check("reset_init_done", a_done, 0);

    // Sweep length, with requests held asserted that must all be dropped
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;
    a_wr_en = 1; a_wr_addr = 10'h000; a_wr_data = 32'hFFFFFFFF; a_wr_be = 4'hF;
    a_rd_en = 1; a_rd_addr = 10'h000;
    sweep_a(n);
    a_wr_en = 0;
    a_rd_en = 0;
    check("init_cycles", n, 1024);
    check("init_done", a_done, 1);
    $display("sweep: %0d cycles, init_done=%0b", n, a_done);

    foreach (vq[i]) drive_a(vq[i]);
    repeat (LAT + 2) tick();
    check("hold_rd_valid", a_valid, 0);
    check("hold_rd_data", a_rd_data, 32'hA5A5A5A5);

    // Row select on the 4096-deep instance
    n = 0;
    while (!b_ready && n < 10000) begin
      tick();
      n++;
    end
    check("b_ready", b_ready, 1);
    b_addrs = '{12'h000, 12'h400, 12'hC00, 12'hFFF, 12'h800};
    b_vals  = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h0};
    for (int i = 0; i < 4; i++) drive_b(1'b1, b_addrs[i], b_vals[i], "b_wr");
    for (int i = 0; i < 5; i++) drive_b(1'b0, b_addrs[i], b_vals[i], $sformatf("b_rd_%03h", b_addrs[i]));
    repeat (LAT + 2) tick();

    // Reset while a read is in flight
    a_rd_en = 1; a_rd_addr = 10'h3A5;
    tick();
    a_rd_en = 0;
    mon_en = 1'b0;
    check("inflight_valid", a_valid, (LAT == 1) ? 1 : 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_drop_valid", a_valid, 0);
    check("rst_drop_data", a_rd_data, 0);
    check("rst_req_ready", a_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;

    // Reset in the middle of the sweep restarts it from address 0
    repeat (500) tick();
    check("mid_sweep_ready", a_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_sweep_rst_valid", a_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    sweep_a(n);
    check("restart_cycles", n, 1024);
    $display("restarted sweep: %0d cycles", n);

    add_vec(0, 10'h000, 32'h0, 4'h0, 1, 10'h3A5, 32'h00000000, "rd_3a5_reswept");
    add_vec(0, 10'h000, 32'h0, 4'h0, 1, 10'h010, 32'h00000000, "rd_010_reswept");
    drive_a(vq[vq.size()-2]);
    drive_a(vq[vq.size()-1]);
    repeat (LAT + 3) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
